dual_port_mem_param: RTL
========================

Name: dual_port_mem_param

Overview:
Parametrised two-port synchronous memory; successor to the fixed 16x1k two-port memory.
- Two fully independent read/write ports; width, depth and collision policy are set by parameters.
- Registered read data with per-port valid strobes, so datapath/control consumers (PC fetch on port 1, load/store on port 2) know exactly when R1/R2 are fresh.
- Optional self-clearing sequence after reset; deterministic resolution of same-address write collisions.

Parameters:
DATA_W, 16, data width of W1/W2/R1/R2
ADDR_W, 16, address port width (matches processor address bus)
DEPTH, 1024, number of words; addresses >= DEPTH are out of range
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting traffic; 0 = contents undefined, ready immediately
WR_PRIORITY, 1, port (1 or 2) whose write wins on a same-address double write
READ_MODE, 0, same-port read+write to same address: 0 = read-first (old data), 1 = write-first (new data)
BYPASS, 1, cross-port read of address written same cycle by other port: 1 = return new data, 0 = old data

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
A1  in  ADDR_W  port 1 address
W1  in  DATA_W  port 1 write data
Write1  in  1  port 1 write enable
Read1  in  1  port 1 read enable
R1  out  DATA_W  port 1 registered read data
Valid1  out  1  one-cycle strobe: R1 updated by a read
A2, W2, Write2, Read2, R2, Valid2  same as port 1, for port 2
Busy  out  1  clear sequence in progress; all port requests ignored
Collision  out  1  one-cycle strobe: both ports wrote the same in-range address
AddrErr  out  1  one-cycle strobe: any enabled access addressed >= DEPTH

Behaviour:
- Reset (reset_n low, async): R1=R2=0, Valid1=Valid2=0, Collision=0, AddrErr=0, clear pointer=0.
  - Busy=1 if CLEAR_ON_RESET, else 0. FSM forced to CLEAR (or READY if CLEAR_ON_RESET=0).
  - Memory contents are not touched by reset itself.
- FSM states CLEAR and READY.
  - CLEAR: each cycle writes 0 to mem[clr_ptr], clr_ptr++. After the edge writing DEPTH-1, go to READY and Busy=0. Total DEPTH cycles.
  - Read/Write inputs are ignored in CLEAR. Valid/Collision/AddrErr stay 0.
  - Reset asserted mid-clear restarts the clear at address 0.
- READY, writes: Writex=1 at an edge with Ax<DEPTH stores Wx into mem[Ax] at that edge.
- READY, reads: Readx=1 sampled at edge k loads Rx and sets Validx=1 for cycle k+1 (latency 1).
  - Rx holds its last value when there is no read. Validx deasserts the following cycle unless Readx was sampled again.
  - Back-to-back reads give continuous Validx.
- Double write to the same address: the WR_PRIORITY port's data is stored and Collision=1 for one cycle. Different addresses: both stored.
- Same-port read+write to the same address: READ_MODE selects old or new data.
- Cross-port read of an address written the same cycle by the other port: BYPASS selects data.
  - With BYPASS=1 and a double write, the returned data is the winning data.
- Out of range (Ax >= DEPTH):
  - Write dropped.
  - Read returns 0 with Validx=1.
  - AddrErr=1 for one cycle.
- Only the low ceil(log2(DEPTH)) address bits index storage, after the range check. No aliasing.

Decomposition:
- Shared package mem_pkg:
  - FSM state encoding (ST_CLEAR, ST_READY).
  - READ_MODE encodings (RD_FIRST=0, WR_FIRST=1).
  - Priority constants (PRI_P1=1, PRI_P2=2).
  - clog2 helper.
- Sub-module dp_ram_core: plain storage array, two write ports, two registered read ports, no policy.
- Top level holds the clear FSM, range checks, collision/bypass muxing and strobes.

Test Plan:
1. Clear: CLEAR_ON_RESET=1, DEPTH=1024, release reset -> Busy=1 for exactly 1024 cycles; then reading addresses 0, 511, 1023 returns 0 with Valid=1 one cycle after Read.
2. Basic write/read: write 100 at A1=0 and 0 at A2=1000, then Read1/Read2 -> R1=100, R2=0 one cycle later, Valid1=Valid2=1 for one cycle. Sweep W1 from 100 down, W2 from 0 up, 30 addresses -> all match.
3. Collision: WR_PRIORITY=1, A1=A2=5, W1=0xAAAA, W2=0x5555, both Write -> Collision=1 one cycle; a later read of 5 returns 0xAAAA. Repeat with WR_PRIORITY=2 -> 0x5555.
4. Same-cycle hazards: mem[7]=0x1111; port1 writes 0x2222 to 7 while port2 reads 7 -> R2=0x2222 (BYPASS=1) or 0x1111 (BYPASS=0). Same-port read+write -> READ_MODE=0 gives 0x1111, READ_MODE=1 gives 0x2222.
5. Out of range: DEPTH=1024, Write1 at A1=1024 with 0xBEEF, then Read1 at 1024 -> AddrErr pulses; R1=0, Valid1=1; mem[0] unchanged.
6. Reset mid-clear: assert reset_n low at clear cycle 300 and release -> Busy high for a full 1024 cycles again. Requests issued during Busy -> no Valid and no memory change.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the parametrised two-port memory: FSM states, read/priority
// policy codes, read-data source select and a constant clog2 helper.
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

    typedef enum logic [1:0] {
        SEL_CORE = 2'd0,
        SEL_FWD  = 2'd1,
        SEL_ZERO = 2'd2
    } rd_sel_e;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    localparam int PRI_P1 = 1;
    localparam int PRI_P2 = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dual_port_mem_param_if.sv
// Bus bundle for the two-port memory. Handshake: a request is taken at every rising
// edge where Writex/Readx is high and Busy is low; there is no ready back-pressure.
interface dual_port_mem_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] A1, A2;
    logic [DATA_W-1:0] W1, W2;
    logic              Write1, Read1, Write2, Read2;
    logic [DATA_W-1:0] R1, R2;
    logic              Valid1, Valid2;
    logic              Busy, Collision, AddrErr;

    modport master (
        output A1, W1, Write1, Read1, A2, W2, Write2, Read2,
        input  R1, Valid1, R2, Valid2, Busy, Collision, AddrErr
    );

    modport slave (
        input  A1, W1, Write1, Read1, A2, W2, Write2, Read2,
        output R1, Valid1, R2, Valid2, Busy, Collision, AddrErr
    );
endinterface

// File: rtl/dp_ram_core.sv
// Plain two-write/two-read storage array with registered read ports; the caller
// guarantees in-range indices and never issues two writes to the same index.
module dp_ram_core #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we1_i,
    input  logic [IDX_W-1:0]  wa1_i,
    input  logic [DATA_W-1:0] wd1_i,
    input  logic              we2_i,
    input  logic [IDX_W-1:0]  wa2_i,
    input  logic [DATA_W-1:0] wd2_i,
    input  logic              re1_i,
    input  logic [IDX_W-1:0]  ra1_i,
    input  logic              re2_i,
    input  logic [IDX_W-1:0]  ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd1_q, rd2_q;

    always_ff @(posedge clk_i) begin
        if (we1_i) mem_q[wa1_i] <= wd1_i;
        if (we2_i) mem_q[wa2_i] <= wd2_i;
    end

    // Reads see the array contents from before this edge's writes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            if (re1_i) rd1_q <= mem_q[ra1_i];
            if (re2_i) rd2_q <= mem_q[ra2_i];
        end
    end

    assign rd1_o = rd1_q;
    assign rd2_o = rd2_q;
endmodule

// File: rtl/dual_port_mem_param.sv
// Two-port memory top: clear-after-reset FSM, range checks, write collision policy,
// same-cycle read forwarding and the Valid/Collision/AddrErr strobes.
module dual_port_mem_param
    import mem_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int DEPTH          = 1024,
    parameter int CLEAR_ON_RESET = 1,
    parameter int WR_PRIORITY    = 1,
    parameter int READ_MODE      = 0,
    parameter int BYPASS         = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dual_port_mem_param_if.slave bus,
    output mem_state_e           dbg_state_o
);
    localparam int                IDX_W   = clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IX = IDX_W'(DEPTH - 1);

    mem_state_e        state_q;
    logic [IDX_W-1:0]  clr_ptr_q;
    logic              busy_q, valid1_q, valid2_q, coll_q, aerr_q;
    rd_sel_e           sel1_q, sel2_q, sel1_d, sel2_d;
    logic [DATA_W-1:0] fwd1_q, fwd2_q, fwd1_d, fwd2_d, win_d;
    logic [DATA_W-1:0] core_rd1, core_rd2;

    logic ready, clearing, in1, in2, same_a;
    logic wr1, wr2, rd1, rd2, coll_d, aerr_d, wr1_eff, wr2_eff, fwd1_hit, fwd2_hit;

    assign ready    = (state_q == ST_READY);
    assign clearing = (state_q == ST_CLEAR);
    assign in1      = {1'b0, bus.A1} < DEPTH_A;
    assign in2      = {1'b0, bus.A2} < DEPTH_A;
    assign same_a   = (bus.A1 == bus.A2);

    assign wr1    = ready & bus.Write1 & in1;
    assign wr2    = ready & bus.Write2 & in2;
    assign rd1    = ready & bus.Read1;
    assign rd2    = ready & bus.Read2;
    assign coll_d = wr1 & wr2 & same_a;
    assign aerr_d = ready & (((bus.Write1 | bus.Read1) & ~in1) |
                             ((bus.Write2 | bus.Read2) & ~in2));

    // The losing side of a same-address double write is simply not issued to the core.
    assign wr1_eff = wr1 & ~(coll_d & (WR_PRIORITY == PRI_P2));
    assign wr2_eff = wr2 & ~(coll_d & (WR_PRIORITY != PRI_P2));
    assign win_d   = (WR_PRIORITY == PRI_P2) ? bus.W2 : bus.W1;

    assign fwd1_hit = rd1 & in1 & ((wr1 & (READ_MODE == WR_FIRST)) | (wr2 & same_a & (BYPASS != 0)));
    assign fwd2_hit = rd2 & in2 & ((wr2 & (READ_MODE == WR_FIRST)) | (wr1 & same_a & (BYPASS != 0)));
    assign fwd1_d   = coll_d ? win_d : (wr1 ? bus.W1 : bus.W2);
    assign fwd2_d   = coll_d ? win_d : (wr2 ? bus.W2 : bus.W1);
    assign sel1_d   = !in1 ? SEL_ZERO : (fwd1_hit ? SEL_FWD : SEL_CORE);
    assign sel2_d   = !in2 ? SEL_ZERO : (fwd2_hit ? SEL_FWD : SEL_CORE);

    dp_ram_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_core (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .we1_i   (clearing | wr1_eff),
        .wa1_i   (clearing ? clr_ptr_q : bus.A1[IDX_W-1:0]),
        .wd1_i   (clearing ? '0 : bus.W1),
        .we2_i   (wr2_eff),
        .wa2_i   (bus.A2[IDX_W-1:0]),
        .wd2_i   (bus.W2),
        .re1_i   (rd1 & in1),
        .ra1_i   (bus.A1[IDX_W-1:0]),
        .re2_i   (rd2 & in2),
        .ra2_i   (bus.A2[IDX_W-1:0]),
        .rd1_o   (core_rd1),
        .rd2_o   (core_rd2)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            busy_q    <= (CLEAR_ON_RESET != 0);
            clr_ptr_q <= '0;
            valid1_q  <= 1'b0;
            valid2_q  <= 1'b0;
            coll_q    <= 1'b0;
            aerr_q    <= 1'b0;
            sel1_q    <= SEL_CORE;
            sel2_q    <= SEL_CORE;
            fwd1_q    <= '0;
            fwd2_q    <= '0;
        end else begin
            valid1_q <= rd1;
            valid2_q <= rd2;
            coll_q   <= coll_d;
            aerr_q   <= aerr_d;
            if (rd1) begin
                sel1_q <= sel1_d;
                fwd1_q <= fwd1_d;
            end
            if (rd2) begin
                sel2_q <= sel2_d;
                fwd2_q <= fwd2_d;
            end
            case (state_q)
                ST_CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + 1'b1;
                    if (clr_ptr_q == LAST_IX) begin
                        state_q <= ST_READY;
                        busy_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.R1 = (sel1_q == SEL_ZERO) ? '0 : ((sel1_q == SEL_FWD) ? fwd1_q : core_rd1);
    assign bus.R2 = (sel2_q == SEL_ZERO) ? '0 : ((sel2_q == SEL_FWD) ? fwd2_q : core_rd2);
    assign bus.Valid1    = valid1_q;
    assign bus.Valid2    = valid2_q;
    assign bus.Busy      = busy_q;
    assign bus.Collision = coll_q;
    assign bus.AddrErr   = aerr_q;
    assign dbg_state_o   = state_q;
endmodule
